// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ps2_pkg
// Purpose  : Shared PS/2 constants, decoder state, event record, ASCII map.
// Revision : 1.0 - initial release
// ============================================================================
package ps2_pkg;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXT     = 2'd1,
        BRK     = 2'd2,
        EXT_BRK = 2'd3
    } ps2_state_e;

    typedef struct packed {
        logic [7:0] scan;
        logic [7:0] ascii;
        logic       brk;
        logic       ext;
    } ps2_evt_t;

    // Scan code set 2, letters and top-row digits only.
    function automatic logic [7:0] ps2_ascii(input logic [7:0] scan);
        logic [7:0] a;
        case (scan)
            8'h1C: a = 8'h41;
            8'h32: a = 8'h42;
            8'h21: a = 8'h43;
            8'h23: a = 8'h44;
            8'h24: a = 8'h45;
            8'h2B: a = 8'h46;
            8'h34: a = 8'h47;
            8'h33: a = 8'h48;
            8'h43: a = 8'h49;
            8'h3B: a = 8'h4A;
            8'h42: a = 8'h4B;
            8'h4B: a = 8'h4C;
            8'h3A: a = 8'h4D;
            8'h31: a = 8'h4E;
            8'h44: a = 8'h4F;
            8'h4D: a = 8'h50;
            8'h15: a = 8'h51;
            8'h2D: a = 8'h52;
            8'h1B: a = 8'h53;
            8'h2C: a = 8'h54;
            8'h3C: a = 8'h55;
            8'h2A: a = 8'h56;
            8'h1D: a = 8'h57;
            8'h22: a = 8'h58;
            8'h35: a = 8'h59;
            8'h1A: a = 8'h5A;
            8'h45: a = 8'h30;
            8'h16: a = 8'h31;
            8'h1E: a = 8'h32;
            8'h26: a = 8'h33;
            8'h25: a = 8'h34;
            8'h2E: a = 8'h35;
            8'h36: a = 8'h36;
            8'h3D: a = 8'h37;
            8'h3E: a = 8'h38;
            8'h46: a = 8'h39;
            default: a = 8'h00;
        endcase
        return a;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_evt_fifo.sv
`default_nettype none
// ============================================================================
// Module   : ps2_evt_fifo
// Purpose  : First-word-fall-through event FIFO; push and pop may coincide
//            when full.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_evt_fifo
    import ps2_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     clrn,
    input  logic     push,
    input  ps2_evt_t push_evt,
    input  logic     pop,
    output logic     full,
    output logic     empty,
    output ps2_evt_t head
);

    localparam int         AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] C_FULL = (AW+1)'(DEPTH);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    ps2_evt_t      mem_q [DEPTH];
    logic          do_push, do_pop;

    always_comb begin
        do_pop   = pop && (count_q != '0);
        do_push  = push && ((count_q != C_FULL) || do_pop);
        wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; count_q alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_evt;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign empty = (count_q == '0);
    assign full  = (count_q == C_FULL);

endmodule
`default_nettype wire

// File: rtl/ps2_key_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ps2_key_ctrl
// Purpose  : PS/2 scan-code decoder (E0/F0 prefixes, typematic filter, held
//            key tracking) feeding an event FIFO. Define PS2_KEY_CNT_EN to add
//            the key_cnt press counter output.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_key_ctrl
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic [7:0] ps2_data,
    input  logic       ps2_valid,
    output logic       ps2_ready,
    output logic       ev_valid,
    input  logic       ev_ready,
    output logic [7:0] ev_scan,
    output logic [7:0] ev_ascii,
    output logic       ev_break,
    output logic       ev_ext,
    output logic       key_down,
    output logic [7:0] cur_ascii
`ifdef PS2_KEY_CNT_EN
    ,
    output logic [7:0] key_cnt
`endif
);

    ps2_state_e state_q, state_d;
    logic       key_down_q, key_down_d;
    logic [7:0] held_q, held_d;

    logic       is_prefix, is_repeat, would_emit;
    logic       accept, push, pop;
    logic       fifo_full, fifo_empty;
    ps2_evt_t   evt, head;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A prefix seen outside IDLE (except F0 after E0) is a protocol error
    // and lands back in IDLE like any completed code.
    always_comb begin
        state_d = state_q;
        if (accept) begin
            case (state_q)
                IDLE: begin
                    if (ps2_data == PS2_EXT)      state_d = EXT;
                    else if (ps2_data == PS2_BRK) state_d = BRK;
                    else                          state_d = IDLE;
                end
                EXT:     state_d = (ps2_data == PS2_BRK) ? EXT_BRK : IDLE;
                BRK:     state_d = IDLE;
                EXT_BRK: state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        is_prefix  = (ps2_data == PS2_EXT) || (ps2_data == PS2_BRK);
        is_repeat  = (state_q == IDLE) && key_down_q && (ps2_data == held_q);
        would_emit = !is_prefix && !is_repeat;
        pop        = ev_ready && !fifo_empty;
        // A pop in the same cycle frees a slot, so a full FIFO can still take it.
        ps2_ready  = !(would_emit && fifo_full && !pop);
        accept     = ps2_valid && ps2_ready;
        push       = accept && would_emit;

        evt.scan   = ps2_data;
        evt.ext    = (state_q == EXT) || (state_q == EXT_BRK);
        evt.brk    = (state_q == BRK) || (state_q == EXT_BRK);
        evt.ascii  = evt.ext ? 8'h00 : ps2_ascii(ps2_data);

        key_down_d = key_down_q;
        held_d     = held_q;
        if (push && !evt.ext) begin
            if (!evt.brk) begin
                key_down_d = 1'b1;
                held_d     = ps2_data;
            end else if (ps2_data == held_q) begin
                key_down_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            key_down_q <= 1'b0;
            held_q     <= 8'h00;
        end else begin
            key_down_q <= key_down_d;
            held_q     <= held_d;
        end
    end

    ps2_evt_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .clrn     (clrn),
        .push     (push),
        .push_evt (evt),
        .pop      (pop),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .head     (head)
    );

    assign ev_valid  = !fifo_empty;
    assign ev_scan   = head.scan;
    assign ev_ascii  = head.ascii;
    assign ev_break  = head.brk;
    assign ev_ext    = head.ext;
    assign key_down  = key_down_q;
    assign cur_ascii = key_down_q ? ps2_ascii(held_q) : 8'h00;

`ifdef PS2_KEY_CNT_EN
    logic [7:0] key_cnt_q, key_cnt_d;

    always_comb begin
        key_cnt_d = key_cnt_q;
        if (push && !evt.brk) begin
            key_cnt_d = key_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            key_cnt_q <= 8'h00;
        end else begin
            key_cnt_q <= key_cnt_d;
        end
    end

    assign key_cnt = key_cnt_q;
`endif

endmodule
`default_nettype wire
